sobel_frame_sequencer: RTL

Frame-level controller for the stochastic Sobel core (`stochWrapper`). It walks a 3x3 window over a source image held in external byte memory and fetches the eight neighbour pixels of each interior position. It launches the core with a start/done handshake and writes each 8-bit edge result to a packed edge memory. It sits between the frame buffers and the core, replacing bench-driven window sequencing.

---
 rtl/sobel_frame_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer
// Walks a 3x3 window over a ROWS x COLS byte image held in external memory.
// For each interior pixel it fetches the eight neighbours, launches the Sobel
// core with a start/done handshake and writes the 8-bit edge result to the
// packed edge memory in raster order.
// Optional feature: define SEQ_TIMEOUT_EN to bound the wait for core_done to
// TIMEOUT_CYCLES; a timed-out window writes 8'h00 and sets err_timeout.
module sobel_frame_sequencer #(
  parameter int ROWS           = 147,
  parameter int COLS           = 143,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic [7:0]        win_p1,
  output logic [7:0]        win_p2,
  output logic [7:0]        win_p3,
  output logic [7:0]        win_p4,
  output logic [7:0]        win_p6,
  output logic [7:0]        win_p7,
  output logic [7:0]        win_p8,
  output logic [7:0]        win_p9,
  output logic              core_start,
  input  logic              core_done,
  input  logic [7:0]        core_z,
  output logic              edge_we,
  output logic [ADDR_W-1:0] edge_addr,
  output logic [7:0]        edge_data
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_A  = ADDR_W'(2);

  state_t            state_r;
  logic [ADDR_W-1:0] i_r;
  logic [ADDR_W-1:0] j_r;
  logic [3:0]        fetch_cnt_r;
  logic              done_q_r;
  logic [7:0]        win_r [8];
  logic [ADDR_W-1:0] next_i_s;
  logic [ADDR_W-1:0] next_j_s;
  logic              last_win_s;
  logic              core_edge_s;
  logic [ADDR_W-1:0] edge_addr_s;
`ifdef SEQ_TIMEOUT_EN
  logic [31:0]       wait_cnt_r;
`endif

  // Neighbour order p1,p2,p3,p4,p6,p7,p8,p9 relative to the window's top-left pixel.
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] ii,
                                                   input logic [ADDR_W-1:0] jj,
                                                   input logic [2:0]        k);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] off;
    base = COLS_A * (ii - ONE_A) + (jj - ONE_A);
    case (k)
      3'd0:    off = ADDR_W'(0);
      3'd1:    off = ONE_A;
      3'd2:    off = TWO_A;
      3'd3:    off = COLS_A;
      3'd4:    off = COLS_A + TWO_A;
      3'd5:    off = COLS_A + COLS_A;
      3'd6:    off = COLS_A + COLS_A + ONE_A;
      default: off = COLS_A + COLS_A + TWO_A;
    endcase
    return base + off;
  endfunction

  assign win_p1 = win_r[0];
  assign win_p2 = win_r[1];
  assign win_p3 = win_r[2];
  assign win_p4 = win_r[3];
  assign win_p6 = win_r[4];
  assign win_p7 = win_r[5];
  assign win_p8 = win_r[6];
  assign win_p9 = win_r[7];

  // Core done edge detect, raster-order successor of (i,j) and the edge write address.
  always_comb begin
    core_edge_s = core_done & ~done_q_r;
    edge_addr_s = (i_r - ONE_A) * (COLS_A - TWO_A) + (j_r - ONE_A);
    next_i_s    = i_r;
    next_j_s    = j_r;
    last_win_s  = 1'b0;
    if (j_r < COLS_A - TWO_A) begin
      next_j_s = j_r + ONE_A;
    end else if (i_r < ROWS_A - TWO_A) begin
      next_i_s = i_r + ONE_A;
      next_j_s = ONE_A;
    end else begin
      last_win_s = 1'b1;
    end
  end

  // Frame sequencer FSM; every output is a register set on entry to its state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      i_r         <= '0;
      j_r         <= '0;
      fetch_cnt_r <= 4'd0;
      done_q_r    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      src_rd      <= 1'b0;
      src_addr    <= '0;
      core_start  <= 1'b0;
      edge_we     <= 1'b0;
      edge_addr   <= '0;
      edge_data   <= 8'h00;
      for (int k = 0; k < 8; k++) win_r[k] <= 8'h00;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_r  <= 32'd0;
`endif
    end else begin
      done_q_r   <= core_done;
      frame_done <= 1'b0;
      core_start <= 1'b0;
      edge_we    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            i_r         <= ONE_A;
            j_r         <= ONE_A;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            fetch_cnt_r <= 4'd0;
            src_rd      <= 1'b1;
            src_addr    <= fetch_addr(ONE_A, ONE_A, 3'd0);
            state_r     <= ST_FETCH;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_FETCH: begin
          // Read data returns one cycle late, so slot k fills on count k+1.
          if (fetch_cnt_r != 4'd0) begin
            win_r[fetch_cnt_r[2:0] - 3'd1] <= src_data;
          end else begin
            win_r[0] <= win_r[0];
          end
          if (fetch_cnt_r < 4'd7) begin
            src_rd   <= 1'b1;
            src_addr <= fetch_addr(i_r, j_r, fetch_cnt_r[2:0] + 3'd1);
          end else begin
            src_rd <= 1'b0;
          end
          if (fetch_cnt_r == 4'd8) begin
            core_start <= 1'b1;
            state_r    <= ST_LAUNCH;
          end else begin
            fetch_cnt_r <= fetch_cnt_r + 4'd1;
          end
        end
        ST_LAUNCH: begin
`ifdef SEQ_TIMEOUT_EN
          wait_cnt_r <= 32'd0;
`endif
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_edge_s) begin
            edge_data <= core_z;
            edge_addr <= edge_addr_s;
            edge_we   <= 1'b1;
            state_r   <= ST_WRITE;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wait_cnt_r == 32'(TIMEOUT_CYCLES - 1)) begin
            edge_data   <= 8'h00;
            edge_addr   <= edge_addr_s;
            edge_we     <= 1'b1;
            err_timeout <= 1'b1;
            state_r     <= ST_WRITE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
`else
          else begin
            state_r <= ST_WAIT;
          end
`endif
        end
        ST_WRITE: begin
          state_r <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (last_win_s) begin
            frame_done <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            i_r         <= next_i_s;
            j_r         <= next_j_s;
            fetch_cnt_r <= 4'd0;
            src_rd      <= 1'b1;
            src_addr    <= fetch_addr(next_i_s, next_j_s, 3'd0);
            state_r     <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          src_rd  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
